// File: rtl/systolic_fir_filter_4tap.sv
// rtl/systolic_fir_filter_4tap.sv - 4-tap transposed systolic FIR with serial coefficient load
//
// Purpose:
//   Four processing elements (pe0..pe3) in transposed systolic form. The input
//   sample x is broadcast to every PE and partial sums ripple from pe3 toward
//   pe0. After each reset the first four x words are shifted in as
//   coefficients (LOAD), after which the block filters every cycle (RUN):
//     y[n] = w0*x[n] + w1*x[n-1] + w2*x[n-2] + w3*x[n-3]
//
// Ports:
//   clock   in   1       rising-edge system clock
//   resetN  in   1       asynchronous active-low reset
//   x       in   DATA_W  signed sample (coefficients during LOAD, data during RUN)
//   y       out  DATA_W  signed registered output, equal to pe0's partial sum
//
// Optional feature:
//   FIR_SATURATE_EN  when defined, product truncation and partial-sum addition
//                    saturate to the signed DATA_W range instead of wrapping.

module systolic_fir_filter_4tap #(
    parameter int DATA_W    = 32,
    parameter int FRAC_BITS = 0,
    parameter int CNT_W     = 8
) (
    input  logic                     clock,
    input  logic                     resetN,
    input  logic signed [DATA_W-1:0] x,
    output logic signed [DATA_W-1:0] y
);

    logic signed [DATA_W-1:0] w0, w1, w2, w3;
    logic signed [DATA_W-1:0] p0, p1, p2, p3;
    logic signed [DATA_W-1:0] p_tail;

    // pe3 is the end of the partial-sum chain, so it accumulates onto zero.
    assign p_tail = '0;

    // Coefficients enter at pe0 and shift toward pe3, so the first loaded word
    // ends up in pe3 and the last in pe0.
    systolic_fir_pe #(.DATA_W(DATA_W), .FRAC_BITS(FRAC_BITS), .CNT_W(CNT_W)) pe0 (
        .clock(clock), .resetN(resetN), .x(x),
        .weight_in(x),  .p_in(p1),     .weight(w0), .p(p0)
    );
    systolic_fir_pe #(.DATA_W(DATA_W), .FRAC_BITS(FRAC_BITS), .CNT_W(CNT_W)) pe1 (
        .clock(clock), .resetN(resetN), .x(x),
        .weight_in(w0), .p_in(p2),     .weight(w1), .p(p1)
    );
    systolic_fir_pe #(.DATA_W(DATA_W), .FRAC_BITS(FRAC_BITS), .CNT_W(CNT_W)) pe2 (
        .clock(clock), .resetN(resetN), .x(x),
        .weight_in(w1), .p_in(p3),     .weight(w2), .p(p2)
    );
    systolic_fir_pe #(.DATA_W(DATA_W), .FRAC_BITS(FRAC_BITS), .CNT_W(CNT_W)) pe3 (
        .clock(clock), .resetN(resetN), .x(x),
        .weight_in(w2), .p_in(p_tail), .weight(w3), .p(p3)
    );

    assign y = p0;

endmodule

// One processing element: coefficient shift stage during LOAD, multiply-
// accumulate stage during RUN. Every PE keeps its own cycle counter and state;
// since all share clock, reset and the same update rule they stay in lockstep.
module systolic_fir_pe #(
    parameter int DATA_W    = 32,
    parameter int FRAC_BITS = 0,
    parameter int CNT_W     = 8
) (
    input  logic                     clock,
    input  logic                     resetN,
    input  logic signed [DATA_W-1:0] x,
    input  logic signed [DATA_W-1:0] weight_in,
    input  logic signed [DATA_W-1:0] p_in,
    output logic signed [DATA_W-1:0] weight,
    output logic signed [DATA_W-1:0] p
);

    typedef enum logic {
        PE_LOAD = 1'b0,
        PE_RUN  = 1'b1
    } pe_state_t;

    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    // Count value on the fourth load edge; the switch to RUN happens there.
    localparam logic [CNT_W-1:0] LOAD_LAST = CNT_W'(3);

    pe_state_t        state, state_next;
    logic [CNT_W-1:0] clock_count;

    logic signed [2*DATA_W-1:0] weight_ext, x_ext, prod_full, prod_shifted;
    logic signed [DATA_W-1:0]   prod, sum;

    assign weight_ext   = {{DATA_W{weight[DATA_W-1]}}, weight};
    assign x_ext        = {{DATA_W{x[DATA_W-1]}}, x};
    assign prod_full    = weight_ext * x_ext;
    assign prod_shifted = prod_full >>> FRAC_BITS;

`ifdef FIR_SATURATE_EN
    localparam logic signed [DATA_W-1:0] SAT_MAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic signed [DATA_W-1:0] SAT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

    logic signed [2*DATA_W-1:0] sat_max_ext, sat_min_ext;
    logic signed [DATA_W:0]     sum_ext;

    assign sat_max_ext = {{DATA_W{1'b0}}, SAT_MAX};
    assign sat_min_ext = {{DATA_W{1'b1}}, SAT_MIN};

    always_comb begin
        prod = prod_shifted[DATA_W-1:0];
        if (prod_shifted > sat_max_ext) begin
            prod = SAT_MAX;
        end else if (prod_shifted < sat_min_ext) begin
            prod = SAT_MIN;
        end
    end

    // One guard bit: the two top bits disagree exactly when the sum left the
    // signed range, and the guard bit then gives the overflow direction.
    assign sum_ext = {p_in[DATA_W-1], p_in} + {prod[DATA_W-1], prod};

    always_comb begin
        sum = sum_ext[DATA_W-1:0];
        if (sum_ext[DATA_W] != sum_ext[DATA_W-1]) begin
            sum = sum_ext[DATA_W] ? SAT_MIN : SAT_MAX;
        end
    end
`else
    logic unused_prod_high;

    // Wrapping arithmetic: the high half of the product is simply discarded.
    assign unused_prod_high = ^prod_shifted[2*DATA_W-1:DATA_W];
    assign prod             = prod_shifted[DATA_W-1:0];
    assign sum              = p_in + prod;
`endif

    always_comb begin
        state_next = state;
        if (state == PE_LOAD && clock_count == LOAD_LAST) begin
            state_next = PE_RUN;
        end
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state       <= PE_LOAD;
            clock_count <= '0;
            weight      <= '0;
            p           <= '0;
        end else begin
            state <= state_next;
            if (clock_count != CNT_MAX) begin
                clock_count <= clock_count + CNT_W'(1);
            end
            if (state == PE_LOAD) begin
                weight <= weight_in;
                p      <= '0;
            end else begin
                p <= sum;
            end
        end
    end

endmodule

// File: tb/tb_systolic_fir_filter_4tap.sv
// tb/tb_systolic_fir_filter_4tap.sv - directed-vector bench for systolic_fir_filter_4tap

module tb_systolic_fir_filter_4tap;

    logic               clock;
    logic               resetN;
    logic signed [31:0] x;
    logic signed [31:0] y;

    int n_checks = 0;
    int n_fail   = 0;

    systolic_fir_filter_4tap dut (
        .clock (clock),
        .resetN(resetN),
        .x     (x),
        .y     (y)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Drive x, take one rising edge, leave time 1 unit past the edge.
    task automatic tick(input logic [31:0] v);
        x = v;
        @(posedge clock);
        #1;
    endtask

    task automatic pulse_reset();
        resetN = 1'b0;
        #1;
        resetN = 1'b1;
    endtask

    task automatic load4(input logic [31:0] c1, input logic [31:0] c2,
                         input logic [31:0] c3, input logic [31:0] c4);
        tick(c1);
        tick(c2);
        tick(c3);
        tick(c4);
    endtask

    task automatic run_seq(input string tag, input logic [31:0] xs[5],
                           input logic [31:0] ys[5], input int n);
        for (int i = 0; i < n; i++) begin
            tick(xs[i]);
            check($sformatf("%s_y%0d", tag, i), y, ys[i]);
        end
    endtask

    logic [31:0] xs [5];
    logic [31:0] ys [5];

    initial begin
        resetN = 1'b0;
        x      = '0;
        #12;
        check("rst_y",     y, 32'd0);
        check("rst_w0",    dut.pe0.weight, 32'd0);
        check("rst_w3",    dut.pe3.weight, 32'd0);
        check("rst_state", 32'(dut.pe0.state), 32'd0);
        check("rst_count", 32'(dut.pe0.clock_count), 32'd0);
        resetN = 1'b1;

        // All-ones load then run
        load4(1, 1, 1, 1);
        check("ones_w0",    dut.pe0.weight, 32'd1);
        check("ones_w1",    dut.pe1.weight, 32'd1);
        check("ones_w2",    dut.pe2.weight, 32'd1);
        check("ones_w3",    dut.pe3.weight, 32'd1);
        check("ones_state", 32'(dut.pe0.state), 32'd1);
        check("ones_count", 32'(dut.pe3.clock_count), 32'd4);
        check("ones_yload", y, 32'd0);
        xs = '{1, 1, 1, 1, 1};
        ys = '{1, 2, 3, 4, 4};
        run_seq("ones", xs, ys, 5);

        // Coefficient order and impulse response
        pulse_reset();
        load4(1, 2, 3, 4);
        check("ord_w3", dut.pe3.weight, 32'd1);
        check("ord_w2", dut.pe2.weight, 32'd2);
        check("ord_w1", dut.pe1.weight, 32'd3);
        check("ord_w0", dut.pe0.weight, 32'd4);
        xs = '{1, 0, 0, 0, 0};
        ys = '{4, 3, 2, 1, 0};
        run_seq("imp", xs, ys, 5);

        // Negative data
        pulse_reset();
        load4(1, 1, 1, 1);
        xs = '{-5, -5, -5, -5, -5};
        ys = '{-5, -10, -15, -20, -20};
        run_seq("neg", xs, ys, 5);

        // Asynchronous reset in the middle of RUN
        #2;
        resetN = 1'b0;
        #1;
        check("mid_y",     y, 32'd0);
        check("mid_state", 32'(dut.pe0.state), 32'd0);
        check("mid_w0",    dut.pe0.weight, 32'd0);
        resetN = 1'b1;
        load4(2, 2, 2, 2);
        xs = '{1, 1, 1, 1, 1};
        ys = '{2, 4, 6, 8, 8};
        run_seq("step", xs, ys, 4);

        // Overflow: 0x40000000 * 4 = 2^32
        pulse_reset();
        load4(32'h4000_0000, 32'h4000_0000, 32'h4000_0000, 32'h4000_0000);
        xs = '{4, 4, 4, 4, 4};
`ifdef FIR_SATURATE_EN
        ys = '{32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF};
`else
        ys = '{0, 0, 0, 0, 0};
`endif
        run_seq("ovf4", xs, ys, 5);

        // Overflow in the accumulation chain: 0x40000000 * 1 summed
        pulse_reset();
        load4(32'h4000_0000, 32'h4000_0000, 32'h4000_0000, 32'h4000_0000);
        xs = '{1, 1, 1, 1, 1};
`ifdef FIR_SATURATE_EN
        ys = '{32'h4000_0000, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF};
`else
        ys = '{32'h4000_0000, 32'h8000_0000, 32'hC000_0000, 32'h0000_0000, 32'h0000_0000};
`endif
        run_seq("ovf1", xs, ys, 5);

        // Counter saturates and state stays in RUN
        repeat (260) tick(0);
        check("cnt_sat",   32'(dut.pe0.clock_count), 32'd255);
        check("sat_state", 32'(dut.pe2.state), 32'd1);
        check("sat_y",     y, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
        $finish;
    end

endmodule
